ibex_wb_queue: RTL
==================

IBEX_WB_QUEUE -- requirements
Module: ibex_wb_queue

Interface
REQ-001 Depth, default 2, number of in-flight writeback entries (legal 1..8; any value, not only powers of two).
REQ-002 Width, default 32, register-file data and PC width.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  in  1  reset, synchronous, active-low.
REQ-005 en_wb_i  in  1  ID/EX offers an instruction for writeback.
REQ-006 instr_type_wb_i  in  2  0 load, 1 store, 2 other (3 treated as other).
REQ-007 pc_id_i  in  Width  PC of offered instruction.
REQ-008 instr_is_compressed_id_i / instr_perf_count_id_i / rf_we_id_i  in  1 each  per-instruction flags.
REQ-009 rf_waddr_id_i  in  5; rf_wdata_id_i  in  Width  ALU/MD result and destination.
REQ-010 lsu_resp_valid_i, lsu_resp_err_i, rf_we_lsu_i  in  1; rf_wdata_lsu_i  in  Width  LSU response for oldest load/store.
REQ-011 ready_wb_o  out  1  offer is accepted this cycle.
REQ-012 rf_we_wb_o  out  1; rf_waddr_wb_o  out  5; rf_wdata_wb_o  out  Width  register-file write port.
REQ-013 rf_wdata_fwd_wb_o  out  Width  head-entry data for forwarding; pc_wb_o  out  Width  head PC.
REQ-014 instr_done_wb_o, perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o  out  1  retirement/perf strobes.
REQ-015 outstanding_load_wb_o, outstanding_store_wb_o  out  1  any valid entry of that type.
REQ-016 count_o  out  clog2(Depth+1)  valid entries.

Function
REQ-017 Storage: in-order circular queue of Depth entries {type, pc, waddr, wdata, we, compressed, perf_count}; head/tail pointers wrap from Depth-1 to 0.
REQ-018 Enqueue: en_wb_i & ready_wb_o writes entry at tail; entry becomes visible one cycle later (min latency 1).
REQ-019 en_wb_i while ready_wb_o=0: offer ignored, no state change; upstream holds it.
REQ-020 head_done = head valid & (head type other | lsu_resp_valid_i).
REQ-021 Retire: at most one entry per cycle, only the head, when head_done; count decrements, head advances.
REQ-022 ready_wb_o = (count < Depth) | head_done; full queue accepts when head retires the same cycle.
REQ-023 Simultaneous enqueue and retire: count unchanged, both pointers advance.
REQ-024 instr_done_wb_o = head_done, combinational.
REQ-025 rf_we_wb_o = head_done & ((type!=load & head we) | (type==load & rf_we_lsu_i)).
REQ-026 rf_waddr_wb_o = head waddr; rf_wdata_wb_o = rf_wdata_lsu_i for load head, else head wdata; both 0 when queue empty.
REQ-027 rf_wdata_fwd_wb_o = head wdata if head valid & head we, else 0; pc_wb_o = head pc if valid, else 0.
REQ-028 perf_instr_ret_wb_o = head_done & head perf_count & ~(lsu_resp_valid_i & lsu_resp_err_i); compressed variant additionally ANDs head compressed.
REQ-029 lsu_resp_valid_i with empty queue or head of type other: ignored; no retire, no write.
REQ-030 outstanding_load/store_wb_o: OR over valid entries of matching type, registered state only (no same-cycle input path).
REQ-031 Depth=1 reproduces single-register writeback-stage behaviour cycle for cycle.

Reset
REQ-032 rst_ni=0 at a rising edge clears count, head, tail and valid state; payload storage not reset.
REQ-033 During and after reset until first enqueue, all outputs 0 except ready_wb_o=1.
REQ-034 Reset mid-operation discards all entries; no retirement strobe in the reset cycle or the cycle after.

Verification
REQ-035 Depth=2: enqueue other (waddr 5, wdata 0xA5A5A5A5, we 1) -> next cycle rf_we_wb_o=1, waddr 5, data 0xA5A5A5A5, instr_done_wb_o=1, count 1->0.
REQ-036 Depth=2: enqueue load, then store; no response -> count 2, ready 0, outstanding_load=outstanding_store=1; lsu_resp_valid_i with rf_we_lsu_i=1, data 0x1234 -> load retires writing 0x1234, ready 1 in the same cycle.
REQ-037 Depth=3, full of loads; hold en_wb_i with responses every cycle -> one accept and one retire per cycle, count stays 3, tail wraps 2->0.
REQ-038 Load head, lsu_resp_valid_i=1, lsu_resp_err_i=1, perf_count=1 -> instr_done_wb_o=1, perf_instr_ret_wb_o=0.
REQ-039 Empty queue, lsu_resp_valid_i=1 -> no write, no done, count 0.
REQ-040 Two entries valid, rst_ni=0 one cycle -> count 0, all outputs 0, ready 1; a later response produces no write.

Source files
------------

// File: rtl/ibex_wb_queue.sv
// Writeback stage as an in-order circular queue of Depth in-flight instructions.
// Only the head entry may retire, at most one per cycle; Depth=1 behaves like a single writeback register.
module ibex_wb_queue #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,

  input  logic                       en_wb_i,
  input  logic [1:0]                 instr_type_wb_i,
  input  logic [Width-1:0]           pc_id_i,
  input  logic                       instr_is_compressed_id_i,
  input  logic                       instr_perf_count_id_i,
  input  logic                       rf_we_id_i,
  input  logic [4:0]                 rf_waddr_id_i,
  input  logic [Width-1:0]           rf_wdata_id_i,

  input  logic                       lsu_resp_valid_i,
  input  logic                       lsu_resp_err_i,
  input  logic                       rf_we_lsu_i,
  input  logic [Width-1:0]           rf_wdata_lsu_i,

  output logic                       ready_wb_o,
  output logic                       rf_we_wb_o,
  output logic [4:0]                 rf_waddr_wb_o,
  output logic [Width-1:0]           rf_wdata_wb_o,
  output logic [Width-1:0]           rf_wdata_fwd_wb_o,
  output logic [Width-1:0]           pc_wb_o,
  output logic                       instr_done_wb_o,
  output logic                       perf_instr_ret_wb_o,
  output logic                       perf_instr_ret_compressed_wb_o,
  output logic                       outstanding_load_wb_o,
  output logic                       outstanding_store_wb_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned CW = $clog2(Depth + 1);
  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PW-1:0] LastPtr = PW'(Depth - 1);
  localparam logic [CW-1:0] FullCount = CW'(Depth);

  localparam logic [1:0] TypeLoad  = 2'd0;
  localparam logic [1:0] TypeStore = 2'd1;

  // Control state (reset)
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q, count_d;
  logic [Depth-1:0] valid_q;

  // Payload storage (not reset)
  logic [1:0]       type_q [Depth];
  logic [Width-1:0] pc_q   [Depth];
  logic [4:0]       waddr_q[Depth];
  logic [Width-1:0] wdata_q[Depth];
  logic             we_q   [Depth];
  logic             comp_q [Depth];
  logic             perf_q [Depth];

  logic             head_valid;
  logic             head_is_load;
  logic             head_is_other;
  logic             head_done;
  logic             enq;
  logic             retire;
  logic [1:0]       h_type;
  logic [Width-1:0] h_pc;
  logic [4:0]       h_waddr;
  logic [Width-1:0] h_wdata;
  logic             h_we;
  logic             h_comp;
  logic             h_perf;
  logic             any_load;
  logic             any_store;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign h_type  = type_q[head_q];
  assign h_pc    = pc_q[head_q];
  assign h_waddr = waddr_q[head_q];
  assign h_wdata = wdata_q[head_q];
  assign h_we    = we_q[head_q];
  assign h_comp  = comp_q[head_q];
  assign h_perf  = perf_q[head_q];

  // Outputs are masked while reset is asserted so stale entries never strobe.
  assign head_valid    = rst_ni & valid_q[head_q];
  assign head_is_load  = (h_type == TypeLoad);
  assign head_is_other = (h_type != TypeLoad) && (h_type != TypeStore);
  assign head_done     = head_valid & (head_is_other | lsu_resp_valid_i);

  assign retire     = head_done;
  assign ready_wb_o = ~rst_ni | (count_q != FullCount) | head_done;
  assign enq        = rst_ni & en_wb_i & ready_wb_o;

  always_comb begin
    count_d = count_q;
    case ({enq, retire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (retire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= ptr_inc(head_q);
      end
      // Set after clear: with Depth=1 head and tail alias and the new entry must win.
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= ptr_inc(tail_q);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      type_q[tail_q]  <= instr_type_wb_i;
      pc_q[tail_q]    <= pc_id_i;
      waddr_q[tail_q] <= rf_waddr_id_i;
      wdata_q[tail_q] <= rf_wdata_id_i;
      we_q[tail_q]    <= rf_we_id_i;
      comp_q[tail_q]  <= instr_is_compressed_id_i;
      perf_q[tail_q]  <= instr_perf_count_id_i;
    end
  end

  always_comb begin
    any_load  = 1'b0;
    any_store = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (valid_q[i] && (type_q[i] == TypeLoad))  any_load  = 1'b1;
      if (valid_q[i] && (type_q[i] == TypeStore)) any_store = 1'b1;
    end
  end

  assign outstanding_load_wb_o  = rst_ni & any_load;
  assign outstanding_store_wb_o = rst_ni & any_store;
  assign count_o                = rst_ni ? count_q : '0;

  assign instr_done_wb_o = head_done;
  assign rf_we_wb_o      = head_done & (head_is_load ? rf_we_lsu_i : h_we);
  assign rf_waddr_wb_o   = head_valid ? h_waddr : 5'd0;
  assign rf_wdata_wb_o   = !head_valid  ? '0 :
                           head_is_load ? rf_wdata_lsu_i : h_wdata;

  assign rf_wdata_fwd_wb_o = (head_valid & h_we) ? h_wdata : '0;
  assign pc_wb_o           = head_valid ? h_pc : '0;

  // A faulting LSU response still completes the instruction but is not counted as retired.
  assign perf_instr_ret_wb_o =
    head_done & h_perf & ~(lsu_resp_valid_i & lsu_resp_err_i);
  assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & h_comp;

endmodule
